// File: rtl/sdpram_arbiter.sv
// Two-client round-robin write/read arbiter in front of a simple dual-port RAM, with a
// read-tag pipeline that routes returned data. Optional macro: SDPRAM_ARB_RAW_HAZARD_EN.
module sdpram_arbiter #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned RD_LAT     = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr0,
   input  logic [ADDR_WIDTH-1:0] wr_addr1,
   input  logic [DATA_WIDTH-1:0] wr_data0,
   input  logic [DATA_WIDTH-1:0] wr_data1,
   output logic [1:0]            wr_gnt,
   input  logic [1:0]            rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr0,
   input  logic [ADDR_WIDTH-1:0] rd_addr1,
   output logic [1:0]            rd_gnt,
   output logic [1:0]            rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  wena,
   output logic [ADDR_WIDTH-1:0] addra,
   output logic [DATA_WIDTH-1:0] dina,
   output logic                  renb,
   output logic [ADDR_WIDTH-1:0] addrb,
   input  logic [DATA_WIDTH-1:0] doutb,
   input  logic                  dvalb,
   output logic                  err
);

   localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic                  wena_q, wena_d;
   logic [ADDR_WIDTH-1:0] addra_q, addra_d;
   logic [DATA_WIDTH-1:0] dina_q, dina_d;
   logic                  renb_q, renb_d;
   logic [ADDR_WIDTH-1:0] addrb_q, addrb_d;
   logic                  rd_id_q, rd_id_d;
   logic [RD_LAT-1:0]     tag_vld_q, tag_vld_d;
   logic [RD_LAT-1:0]     tag_id_q, tag_id_d;
   logic [CNT_W-1:0]      blank_q, blank_d;
   logic                  err_q, err_d;

   logic [1:0]            wr_win, rd_win;
   logic [ADDR_WIDTH-1:0] wr_waddr, rd_raddr;
   logic                  tag_out_vld, blank_done;

   function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
      logic [1:0] gnt;
      gnt = req;
      if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
      return gnt;
   endfunction

   // Combinational grants, forced off while reset is asserted
   always_comb begin
      wr_win   = rst ? rr_pick(wr_req, wr_ptr_q) : 2'b00;
      rd_win   = rst ? rr_pick(rd_req, rd_ptr_q) : 2'b00;
      wr_waddr = wr_win[1] ? wr_addr1 : wr_addr0;
      rd_raddr = rd_win[1] ? rd_addr1 : rd_addr0;
`ifdef SDPRAM_ARB_RAW_HAZARD_EN
      // Same-address read backs off one cycle so it observes the new write data
      if ((|wr_win) && (|rd_win) && (wr_waddr == rd_raddr)) rd_win = 2'b00;
`endif
   end

   // Next-state: pointers, RAM port registers, tag pipeline, post-reset blanking, error
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      wena_d    = 1'b0;
      addra_d   = addra_q;
      dina_d    = dina_q;
      renb_d    = 1'b0;
      addrb_d   = addrb_q;
      rd_id_d   = rd_id_q;
      tag_vld_d = tag_vld_q;
      tag_id_d  = tag_id_q;
      blank_d   = blank_q;
      err_d     = err_q;

      if (|wr_win) begin
         wr_ptr_d = ~wr_win[1];
         wena_d   = 1'b1;
         addra_d  = wr_waddr;
         dina_d   = wr_win[1] ? wr_data1 : wr_data0;
      end
      if (|rd_win) begin
         rd_ptr_d = ~rd_win[1];
         renb_d   = 1'b1;
         addrb_d  = rd_raddr;
         rd_id_d  = rd_win[1];
      end

      tag_vld_d[0] = renb_q;
      tag_id_d[0]  = rd_id_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_id_d[i]  = tag_id_q[i-1];
      end

      if (blank_q != '0) blank_d = blank_q - CNT_W'(1);
      if (blank_done && (dvalb != tag_out_vld)) err_d = 1'b1;
   end

   assign tag_out_vld = tag_vld_q[RD_LAT-1];
   assign blank_done  = (blank_q == '0);

   // Return data is steered by the output-stage tag
   always_comb begin
      rd_valid = 2'b00;
      if (rst && dvalb && tag_out_vld && blank_done)
         rd_valid = tag_id_q[RD_LAT-1] ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         wena_q    <= 1'b0;
         addra_q   <= '0;
         dina_q    <= '0;
         renb_q    <= 1'b0;
         addrb_q   <= '0;
         rd_id_q   <= 1'b0;
         tag_vld_q <= '0;
         tag_id_q  <= '0;
         blank_q   <= CNT_W'(RD_LAT);
         err_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         wena_q    <= wena_d;
         addra_q   <= addra_d;
         dina_q    <= dina_d;
         renb_q    <= renb_d;
         addrb_q   <= addrb_d;
         rd_id_q   <= rd_id_d;
         tag_vld_q <= tag_vld_d;
         tag_id_q  <= tag_id_d;
         blank_q   <= blank_d;
         err_q     <= err_d;
      end
   end

   assign wr_gnt  = wr_win;
   assign rd_gnt  = rd_win;
   assign rd_data = doutb;
   assign wena    = wena_q;
   assign addra   = addra_q;
   assign dina    = dina_q;
   assign renb    = renb_q;
   assign addrb   = addrb_q;
   assign err     = err_q;

endmodule
